// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt latch/arbiter: source count, index
// width, presentation FSM states and a one-hot helper.
package irq_pkg;

    localparam int IRQ_N = 8;
    localparam int IRQ_W = 3;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PRESENT
    } irq_state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [IRQ_N-1:0] irq_onehot(input logic [IRQ_W-1:0] idx);
        logic [IRQ_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_latch_arbiter_penc.sv
// 8-to-3 priority encoder: bin is the index of the highest set bit of data,
// empty flags an all-zero input (bin is then 0).
module priorityEncoder8to3 (
    input  logic [7:0] data,
    output logic [2:0] bin,
    output logic       empty
);

    // Scan upwards so the highest set bit is the last one written.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        bin   = '0;
        empty = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (data[i]) begin
                bin   = 3'(i);
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_latch_arbiter.sv
// Edge-latching interrupt arbiter. Rising edges on req are latched into a
// pending register; the highest-priority enabled pending source is
// presented on out_idx with a valid/ready handshake, one grant per cycle.
// Lost edges (a rise while still pending) set sticky overrun flags.
// Optional per-source enable mask: define IRQ_MASK_EN.
module irq_latch_arbiter
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
`ifdef IRQ_MASK_EN
    input  logic [IRQ_N-1:0] mask,
`endif
    input  logic [IRQ_N-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IRQ_W-1:0] out_idx,
    output logic [IRQ_N-1:0] overrun,
    input  logic             clr_overrun
);

    logic [IRQ_N-1:0] r_req_q;
    logic [IRQ_N-1:0] r_pending;
    logic [IRQ_N-1:0] r_overrun;
    logic [IRQ_W-1:0] r_out_idx;
    irq_state_t       r_state;

    logic [IRQ_N-1:0] w_enable;
    logic [IRQ_N-1:0] w_rise;
    logic             w_handshake;
    logic [IRQ_N-1:0] w_grant_clr;
    logic [IRQ_N-1:0] w_eligible;
    logic [IRQ_N-1:0] w_pending_next;
    logic [IRQ_N-1:0] w_overrun_set;
    logic [IRQ_N-1:0] w_overrun_next;
    logic [IRQ_N-1:0] w_enc_data;
    logic [IRQ_W-1:0] w_enc_bin;
    logic             w_enc_empty;
    irq_state_t       w_state_next;
    logic [IRQ_W-1:0] w_out_idx_next;

`ifdef IRQ_MASK_EN
    assign w_enable = mask;
`else
    assign w_enable = '1;
`endif

    assign out_valid   = (r_state == IRQ_PRESENT);
    assign out_idx     = r_out_idx;
    assign overrun     = r_overrun;

    assign w_rise      = req & ~r_req_q;
    assign w_handshake = out_valid && out_ready;
    assign w_grant_clr = w_handshake ? irq_onehot(r_out_idx) : '0;
    assign w_eligible  = r_pending & w_enable;

    // A rise in the same cycle as its own clear re-pends the source and is
    // not an overrun, because the earlier edge has just been consumed.
    assign w_pending_next = (r_pending & ~w_grant_clr) | w_rise;
    assign w_overrun_set  = w_rise & r_pending & ~w_grant_clr;
    assign w_overrun_next = (clr_overrun ? '0 : r_overrun) | w_overrun_set;

    // The granted bit is masked out so a handshake can load the next winner
    // on the same edge; in IDLE the clear vector is zero.
    assign w_enc_data = w_eligible & ~w_grant_clr;

    priorityEncoder8to3 u_penc (
        .data  (w_enc_data),
        .bin   (w_enc_bin),
        .empty (w_enc_empty)
    );

    // Next-state and next-index selection for the presentation FSM.
    always_comb begin
        w_state_next   = r_state;
        w_out_idx_next = r_out_idx;
        case (r_state)
            IRQ_IDLE: begin
                if (!w_enc_empty) begin
                    w_state_next   = IRQ_PRESENT;
                    w_out_idx_next = w_enc_bin;
                end
            end
            IRQ_PRESENT: begin
                // Without a handshake the presented index is held, even if
                // a higher-priority source or a mask change arrives.
                if (w_handshake) begin
                    if (!w_enc_empty) begin
                        w_out_idx_next = w_enc_bin;
                    end else begin
                        w_state_next = IRQ_IDLE;
                    end
                end
            end
            default: w_state_next = IRQ_IDLE;
        endcase
    end

    // FSM state and presented index registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state   <= IRQ_IDLE;
            r_out_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_out_idx <= w_out_idx_next;
        end
    end

    // Edge detector, pending and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // req_q tracks req during reset so a line already high when
            // reset releases is not mistaken for a new edge.
            r_req_q   <= req;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_req_q   <= req;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
        end
    end

endmodule

// File: tb/tb_irq_latch_arbiter.sv
// Self-checking bench for irq_latch_arbiter: directed scenarios followed by
// randomized traffic, all checked against a set-based reference model.
module tb_irq_latch_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] mask;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] overrun;
    logic       clr_overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_req_q;
    logic [7:0] m_pend;
    logic [7:0] m_ovr;
    bit         m_valid;
    int         m_idx;

    irq_latch_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef IRQ_MASK_EN
        .mask        (mask),
`endif
        .req         (req),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model with the inputs applied now, clock the DUT, then
    // compare all outputs one time unit after the edge.
    task automatic step();
        logic [7:0] rise;
        logic [7:0] clr;
        logic [7:0] en;
        logic [7:0] nxt_pend;
        logic [7:0] nxt_ovr;
        bit         hs;
        int         h;
        if (!rst_n) begin
            m_req_q = req;
            m_pend  = '0;
            m_ovr   = '0;
            m_valid = 1'b0;
            m_idx   = 0;
        end else begin
`ifdef IRQ_MASK_EN
            en = mask;
`else
            en = 8'hFF;
`endif
            rise = req & ~m_req_q;
            hs   = m_valid && out_ready;
            clr  = '0;
            if (hs) clr[m_idx] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                nxt_pend[i] = (m_pend[i] && !clr[i]) || rise[i];
                nxt_ovr[i]  = (m_ovr[i] && !clr_overrun) || (rise[i] && m_pend[i] && !clr[i]);
            end
            if (!m_valid) begin
                h = highest(m_pend & en);
                if (h >= 0) begin
                    m_valid = 1'b1;
                    m_idx   = h;
                end
            end else if (hs) begin
                h = highest(m_pend & en & ~clr);
                if (h >= 0) m_idx = h;
                else        m_valid = 1'b0;
            end
            m_pend  = nxt_pend;
            m_ovr   = nxt_ovr;
            m_req_q = req;
        end
        @(posedge clk);
        #1;
        check("model_valid", 32'(out_valid), 32'(m_valid));
        check("model_idx", 32'(out_idx), 32'(m_idx));
        check("model_overrun", 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        mask        = 8'hFF;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
        m_req_q     = '0;
        m_pend      = '0;
        m_ovr       = '0;
        m_valid     = 1'b0;
        m_idx       = 0;

        // Reset state
        step();
        step();
        check("reset_valid", 32'(out_valid), 0);
        check("reset_idx", 32'(out_idx), 0);
        check("reset_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        step();

        // Single source: pending at first edge, presented at the second
        req = 8'h08;
        step();
        check("single_lat_valid", 32'(out_valid), 0);
        step();
        check("single_valid", 32'(out_valid), 1);
        check("single_idx", 32'(out_idx), 3);
        out_ready = 1'b1;
        step();
        check("single_done", 32'(out_valid), 0);
        req       = '0;
        out_ready = 1'b0;
        step();

        // Priority and hold
        req = 8'h05;
        step();
        step();
        check("prio_idx2", 32'(out_idx), 2);
        req = 8'h85;
        step();
        step();
        check("hold_idx2", 32'(out_idx), 2);
        check("hold_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        check("seq_idx7", 32'(out_idx), 7);
        step();
        check("seq_idx0", 32'(out_idx), 0);
        check("seq_valid0", 32'(out_valid), 1);
        step();
        check("seq_idle", 32'(out_valid), 0);
        req       = '0;
        out_ready = 1'b0;
        step();

        // Overrun: two pulses on req[1] before the grant is taken
        req = 8'h02; step();
        req = 8'h00; step();
        req = 8'h02; step();
        req = 8'h00; step();
        check("ovr_set", 32'(overrun), 32'h02);
        check("ovr_idx1", 32'(out_idx), 1);
        out_ready = 1'b1;
        step();
        step();
        check("ovr_one_grant", 32'(out_valid), 0);
        clr_overrun = 1'b1;
        step();
        check("ovr_clr", 32'(overrun), 0);
        clr_overrun = 1'b0;
        out_ready   = 1'b0;
        step();

        // Rise coinciding with its own clear re-pends without overrun
        req = 8'h10; step();
        step();
        check("rvc_idx4", 32'(out_idx), 4);
        req = 8'h00; step();
        req       = 8'h10;
        out_ready = 1'b1;
        step();
        check("rvc_gap", 32'(out_valid), 0);
        step();
        check("rvc_regrant_valid", 32'(out_valid), 1);
        check("rvc_regrant_idx", 32'(out_idx), 4);
        step();
        check("rvc_no_overrun", 32'(overrun[4]), 0);
        check("rvc_held_no_rise", 32'(out_valid), 0);
        req       = '0;
        out_ready = 1'b0;
        step();

        // Reset with req held high, then reset mid-presentation
        req   = 8'hFF;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("rst_held_no_grant", 32'(out_valid), 0);
        req = 8'h00; step();
        req = 8'h20; step();
        step();
        check("rst_mid_present", 32'(out_valid), 1);
        rst_n = 1'b0;
        step();
        check("rst_mid_cleared", 32'(out_valid), 0);
        rst_n = 1'b1;
        req   = '0;
        step();
        step();
        check("rst_discarded", 32'(out_valid), 0);

`ifdef IRQ_MASK_EN
        // Masked source latches but is granted only once enabled
        mask = 8'hFE;
        step();
        req = 8'h01; step();
        step();
        check("mask_blocked", 32'(out_valid), 0);
        mask = 8'hFF;
        step();
        check("mask_grant_valid", 32'(out_valid), 1);
        check("mask_grant_idx", 32'(out_idx), 0);
        req = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            req         = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            out_ready   = ($urandom_range(0, 2) != 0);
            clr_overrun = ($urandom_range(0, 15) == 0);
            rst_n       = ($urandom_range(0, 199) != 0);
`ifdef IRQ_MASK_EN
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
`endif
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
